// File: rtl/btn_reset_conditioner.sv
// -----------------------------------------------------------------------------
// btn_reset_conditioner
//   Conditions the board push-buttons and the CPU reset button for the SoC top.
//   Each button channel is synchronised, then debounced by a small two-state
//   FSM that emits a clean level plus one-cycle press/release pulses. A reset
//   stretcher holds sys_resetn low for RESET_HOLD_CYCLES after its cause (the
//   hardware reset button or a bus-side soft-reset request) goes away.
//
// Ports
//   clk          : system clock (100 MHz)
//   btnCpuReset  : asynchronous active-low reset for every flop in this block
//   btn_raw      : raw asynchronous button inputs, active high
//   soft_rst_req : synchronous soft-reset request, active high, any length
//   btn_level    : debounced button level
//   btn_press    : one-cycle pulse on an accepted 0->1 change
//   btn_release  : one-cycle pulse on an accepted 1->0 change
//   sys_resetn   : stretched active-low system reset, driven from a flop
//   rst_busy     : high while the hold counter is running
// -----------------------------------------------------------------------------
module btn_reset_conditioner #(
   parameter int NUM_BTN           = 2,
   parameter int SYNC_STAGES       = 2,
   parameter int DEBOUNCE_CYCLES   = 100000,
   parameter int RESET_HOLD_CYCLES = 16
) (
   input  logic               clk,
   input  logic               btnCpuReset,
   input  logic [NUM_BTN-1:0] btn_raw,
   input  logic               soft_rst_req,
   output logic [NUM_BTN-1:0] btn_level,
   output logic [NUM_BTN-1:0] btn_press,
   output logic [NUM_BTN-1:0] btn_release,
   output logic               sys_resetn,
   output logic               rst_busy
);

   localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int HW = $clog2(RESET_HOLD_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [HW-1:0] HOLD_INIT = HW'(RESET_HOLD_CYCLES);

   typedef enum logic {DB_STABLE, DB_COUNTING} db_state_e;
   typedef enum logic {RS_HOLD, RS_RUN}        rs_state_e;

   logic [SYNC_STAGES-1:0] sync_q [NUM_BTN];
   logic [NUM_BTN-1:0]     sync_last;

   db_state_e          db_state_q [NUM_BTN];
   db_state_e          db_state_d [NUM_BTN];
   logic [CW-1:0]      cnt_q [NUM_BTN];
   logic [CW-1:0]      cnt_d [NUM_BTN];
   logic [NUM_BTN-1:0] db_toggle;
   logic [NUM_BTN-1:0] level_q, level_d;
   logic [NUM_BTN-1:0] press_q, press_d;
   logic [NUM_BTN-1:0] release_q, release_d;

   rs_state_e     rs_state_q, rs_state_d;
   logic [HW-1:0] hold_q, hold_d;
   logic          resetn_q, resetn_d;
   logic          busy_q, busy_d;

   // ---------------------------------------------------------------- state regs
   always_ff @(posedge clk or negedge btnCpuReset) begin
      if (!btnCpuReset) begin
         for (int unsigned i = 0; i < NUM_BTN; i++) begin
            sync_q[i]     <= '0;
            db_state_q[i] <= DB_STABLE;
            cnt_q[i]      <= '0;
         end
         level_q    <= '0;
         press_q    <= '0;
         release_q  <= '0;
         rs_state_q <= RS_HOLD;
         hold_q     <= HOLD_INIT;
         resetn_q   <= 1'b0;
         busy_q     <= 1'b1;
      end else begin
         for (int unsigned i = 0; i < NUM_BTN; i++) begin
            sync_q[i]     <= {sync_q[i][SYNC_STAGES-2:0], btn_raw[i]};
            db_state_q[i] <= db_state_d[i];
            cnt_q[i]      <= cnt_d[i];
         end
         level_q    <= level_d;
         press_q    <= press_d;
         release_q  <= release_d;
         rs_state_q <= rs_state_d;
         hold_q     <= hold_d;
         resetn_q   <= resetn_d;
         busy_q     <= busy_d;
      end
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      sync_last = '0;
      db_toggle = '0;
      for (int unsigned i = 0; i < NUM_BTN; i++) begin
         sync_last[i]  = sync_q[i][SYNC_STAGES-1];
         db_state_d[i] = db_state_q[i];
         cnt_d[i]      = cnt_q[i];
         case (db_state_q[i])
            DB_STABLE: begin
               if (sync_last[i] != level_q[i]) begin
                  // A single-cycle debounce accepts the change straight away.
                  if (DEBOUNCE_CYCLES == 1) begin
                     db_toggle[i] = 1'b1;
                  end else begin
                     db_state_d[i] = DB_COUNTING;
                     cnt_d[i]      = CW'(1);
                  end
               end
            end
            DB_COUNTING: begin
               if (sync_last[i] == level_q[i]) begin
                  db_state_d[i] = DB_STABLE;
                  cnt_d[i]      = '0;
               end else if (cnt_q[i] == CNT_LAST) begin
                  db_toggle[i]  = 1'b1;
                  db_state_d[i] = DB_STABLE;
                  cnt_d[i]      = '0;
               end else begin
                  cnt_d[i] = cnt_q[i] + CW'(1);
               end
            end
            default: begin
               db_state_d[i] = DB_STABLE;
               cnt_d[i]      = '0;
            end
         endcase
      end

      // Soft request wins over the countdown and keeps reloading while held.
      rs_state_d = rs_state_q;
      hold_d     = hold_q;
      if (soft_rst_req) begin
         rs_state_d = RS_HOLD;
         hold_d     = HOLD_INIT;
      end else if (rs_state_q == RS_HOLD) begin
         hold_d = hold_q - HW'(1);
         if (hold_q == HW'(1)) begin
            rs_state_d = RS_RUN;
         end
      end
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      level_d   = level_q ^ db_toggle;
      press_d   = db_toggle & ~level_q;
      release_d = db_toggle & level_q;
      resetn_d  = (rs_state_d == RS_RUN);
      busy_d    = (rs_state_d == RS_HOLD);

      btn_level   = level_q;
      btn_press   = press_q;
      btn_release = release_q;
      sys_resetn  = resetn_q;
      rst_busy    = busy_q;
   end

endmodule

// File: tb/tb_btn_reset_conditioner.sv
module tb_btn_reset_conditioner;

   localparam int NB = 2;
   localparam int S  = 2;
   localparam int D  = 4;
   localparam int H  = 16;
   localparam int HL = S + D;

   logic          clk;
   logic          btnCpuReset;
   logic [NB-1:0] btn_raw;
   logic          soft_rst_req;
   logic [NB-1:0] btn_level;
   logic [NB-1:0] btn_press;
   logic [NB-1:0] btn_release;
   logic          sys_resetn;
   logic          rst_busy;

   int checks = 0;
   int errors = 0;

   btn_reset_conditioner #(
      .NUM_BTN          (NB),
      .SYNC_STAGES      (S),
      .DEBOUNCE_CYCLES  (D),
      .RESET_HOLD_CYCLES(H)
   ) dut (
      .clk         (clk),
      .btnCpuReset (btnCpuReset),
      .btn_raw     (btn_raw),
      .soft_rst_req(soft_rst_req),
      .btn_level   (btn_level),
      .btn_press   (btn_press),
      .btn_release (btn_release),
      .sys_resetn  (sys_resetn),
      .rst_busy    (rst_busy)
   );

   // Posedges at 7,17,27,... so no reset edge coincides with a clock edge.
   initial begin
      clk = 1'b0;
      #2;
      forever #5 clk = ~clk;
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, exp);
      end
   endtask

   // ------------------------------------------------------------- model
   // Level toggles when the last D synchronised samples all differ from it;
   // a synchronised sample seen at edge n is the raw value sampled S edges
   // earlier. sys_resetn is high once H edges have passed since its cause.
   bit mon_en   = 1'b0;
   bit rst_seen = 1'b0;
   bit hist [NB][HL];
   bit [NB-1:0] m_level, m_press, m_rel;
   int since;

   initial forever begin
      @(posedge clk);
      rst_seen = btnCpuReset;
   end

   initial forever begin
      @(negedge clk);
      if (mon_en) begin
         if (!btnCpuReset || !rst_seen) begin
            for (int c = 0; c < NB; c++)
               for (int j = 0; j < HL; j++) hist[c][j] = 1'b0;
            m_level = '0;
            m_press = '0;
            m_rel   = '0;
            since   = 0;
         end else begin
            for (int c = 0; c < NB; c++) begin
               bit all_diff;
               for (int j = HL - 1; j > 0; j--) hist[c][j] = hist[c][j-1];
               hist[c][0] = btn_raw[c];
               all_diff = 1'b1;
               for (int j = S; j < HL; j++)
                  if (hist[c][j] == m_level[c]) all_diff = 1'b0;
               m_press[c] = 1'b0;
               m_rel[c]   = 1'b0;
               if (all_diff) begin
                  m_level[c] = ~m_level[c];
                  if (m_level[c]) m_press[c] = 1'b1;
                  else            m_rel[c]   = 1'b1;
               end
            end
            if (soft_rst_req)  since = 0;
            else if (since < H) since++;
         end
         chk("mon_level",   int'(btn_level),   int'(m_level));
         chk("mon_press",   int'(btn_press),   int'(m_press));
         chk("mon_release", int'(btn_release), int'(m_rel));
         chk("mon_resetn",  int'(sys_resetn),  (since >= H) ? 1 : 0);
         chk("mon_busy",    int'(rst_busy),    (since >= H) ? 0 : 1);
         chk("mon_excl",    int'(btn_press & btn_release), 0);
      end
   end

   // ------------------------------------------------------------- helpers
   task automatic wait_neg();
      @(negedge clk);
      #1;
   endtask

   task automatic count_pulses(input int n, input int ch, input bit rel, output int cnt);
      cnt = 0;
      repeat (n) begin
         @(posedge clk);
         #1;
         if (rel ? btn_release[ch] : btn_press[ch]) cnt++;
      end
   endtask

   // ------------------------------------------------------------- directed
   initial begin
      int n;
      logic [NB-1:0] lvl_save;

      btnCpuReset  = 1'b1;
      btn_raw      = '0;
      soft_rst_req = 1'b0;

      // 1: asynchronous assertion, release, stretch to the 16th edge
      #30 btnCpuReset = 1'b0;
      #1;
      chk("rst_async_resetn", int'(sys_resetn), 0);
      chk("rst_async_busy",   int'(rst_busy),   1);
      chk("rst_async_level",  int'(btn_level),  0);
      chk("rst_async_pulses", int'({btn_press, btn_release}), 0);
      mon_en = 1'b1;
      #69 btnCpuReset = 1'b1;
      for (int k = 1; k <= H; k++) begin
         @(posedge clk);
         #1;
         if (k == H - 1) chk("hold_edge15", int'(sys_resetn), 0);
         if (k == H) begin
            chk("hold_edge16_resetn", int'(sys_resetn), 1);
            chk("hold_edge16_busy",   int'(rst_busy),   0);
         end
      end

      // 2: ch0 press, accepted on the 6th edge
      wait_neg();
      btn_raw[0] = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         if (k == 5) chk("press_edge5_level", int'(btn_level[0]), 0);
         if (k == 6) begin
            chk("press_edge6_level", int'(btn_level[0]), 1);
            chk("press_edge6_pulse", int'(btn_press[0]), 1);
            chk("press_edge6_ch1",   int'(btn_level[1]), 0);
         end
         if (k == 7) chk("press_edge7_pulse", int'(btn_press[0]), 0);
      end

      // 3: release back to 0, then a 3-cycle glitch, then a clean release
      wait_neg();
      btn_raw[0] = 1'b0;
      count_pulses(10, 0, 1'b1, n);
      chk("release1_count", n, 1);
      wait_neg();
      btn_raw[0] = 1'b1;
      repeat (3) @(posedge clk);
      wait_neg();
      btn_raw[0] = 1'b0;
      count_pulses(10, 0, 1'b0, n);
      chk("glitch_press_count", n, 0);
      chk("glitch_level", int'(btn_level[0]), 0);
      wait_neg();
      btn_raw[0] = 1'b1;
      count_pulses(10, 0, 1'b0, n);
      chk("repress_count", n, 1);
      wait_neg();
      btn_raw[0] = 1'b0;
      count_pulses(12, 0, 1'b1, n);
      chk("release2_count", n, 1);

      // 4: one-cycle soft reset, then a 10-cycle soft reset
      wait_neg();
      btn_raw[1] = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      lvl_save = btn_level;
      chk("pre_soft_level", int'(lvl_save), 2);
      wait_neg();
      soft_rst_req = 1'b1;
      @(posedge clk);
      #1;
      chk("soft1_fall", int'(sys_resetn), 0);
      wait_neg();
      soft_rst_req = 1'b0;
      for (int k = 1; k <= H; k++) begin
         @(posedge clk);
         #1;
         if (k == H - 1) chk("soft1_edge15", int'(sys_resetn), 0);
         if (k == H)     chk("soft1_edge16", int'(sys_resetn), 1);
      end
      chk("soft1_level_kept", int'(btn_level), int'(lvl_save));
      wait_neg();
      soft_rst_req = 1'b1;
      for (int k = 1; k <= 10; k++) begin
         @(posedge clk);
         #1;
         if (k == 1) chk("soft10_fall", int'(sys_resetn), 0);
      end
      wait_neg();
      soft_rst_req = 1'b0;
      for (int k = 1; k <= H; k++) begin
         @(posedge clk);
         #1;
         if (k == H - 1) chk("soft10_edge15", int'(sys_resetn), 0);
         if (k == H)     chk("soft10_edge16", int'(sys_resetn), 1);
      end

      // 5: hardware reset while ch1 is mid-count
      wait_neg();
      btn_raw[1] = 1'b0;
      repeat (10) @(posedge clk);
      wait_neg();
      btn_raw[0] = 1'b1;
      repeat (10) @(posedge clk);
      wait_neg();
      btn_raw[1] = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      btnCpuReset = 1'b0;
      #1;
      chk("midrst_level",  int'(btn_level),  0);
      chk("midrst_resetn", int'(sys_resetn), 0);
      chk("midrst_pulses", int'({btn_press, btn_release}), 0);
      @(negedge clk);
      wait_neg();
      btnCpuReset = 1'b1;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         if (k == 5) chk("midrst_edge5_level", int'(btn_level[1]), 0);
         if (k == 6) begin
            chk("midrst_edge6_level", int'(btn_level[1]), 1);
            chk("midrst_edge6_press", int'(btn_press[1]), 1);
         end
         if (k == 7) chk("midrst_edge7_press", int'(btn_press[1]), 0);
      end

      // 6: ch0 rises while ch1 falls on the same edge
      wait_neg();
      btn_raw[0] = 1'b0;
      repeat (12) @(posedge clk);
      wait_neg();
      btn_raw[0] = 1'b1;
      btn_raw[1] = 1'b0;
      for (int k = 1; k <= 7; k++) begin
         @(posedge clk);
         #1;
         if (k == 6) begin
            chk("both_press0",   int'(btn_press[0]),   1);
            chk("both_release1", int'(btn_release[1]), 1);
         end
         if (k == 7) chk("both_after", int'({btn_press, btn_release}), 0);
      end

      repeat (20) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
